sm_ram_queued: RTL and testbench



---
 rtl/sm_ram_queued.sv | 154 +++++++++++++++
 tb/tb_sm_ram_queued.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ram_queued.sv
// Word RAM with an in-order request queue, programmable service delay and split valid/ready response.
// Define SM_RAM_QUEUED_JITTER_EN to add 0..7 cycles of LFSR-driven jitter to each service delay.
module sm_ram_queued #(
  parameter int SIZE   = 64,
  parameter int DELAY  = 4,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               a,
  input  logic                      we,
  input  logic [3:0]                be,
  input  logic [31:0]               wd,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [31:0]               rd,
  output logic [$clog2(QDEPTH):0]   pending
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers where rsp_valid && rsp_ready. Response fields hold while stalled.

  localparam int AW  = $clog2(SIZE);
  localparam int QW  = $clog2(QDEPTH);
  localparam int DLY = (DELAY < 1) ? 1 : ((DELAY > 255) ? 255 : DELAY);
  localparam logic [7:0] DLY_M1 = 8'(DLY - 1);
  localparam logic [QW:0] FULL  = (QW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  state_t state;

  logic [7:0]    cnt;
  logic [7:0]    start_cnt;
  logic [AW-1:0] q_idx [QDEPTH];
  logic          q_we  [QDEPTH];
  logic [3:0]    q_be  [QDEPTH];
  logic [31:0]   q_wd  [QDEPTH];
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [QW:0]   count;
  logic [31:0]   mem [SIZE];

  logic          push;
  logic          pop;
  logic          access;
  logic [AW-1:0] h_idx;
  logic          h_we;
  logic [3:0]    h_be;
  logic [31:0]   h_wd;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{a[31:AW+2], a[1:0]};

  // req_ready depends only on the registered occupancy, never on rsp_ready.
  assign req_ready = (count != FULL);
  assign pending   = count;
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign access    = (state == S_BUSY) && (cnt == 8'd0);

  assign h_idx = q_idx[rd_ptr];
  assign h_we  = q_we[rd_ptr];
  assign h_be  = q_be[rd_ptr];
  assign h_wd  = q_wd[rd_ptr];

`ifdef SM_RAM_QUEUED_JITTER_EN
  logic [7:0] lfsr;
  logic [8:0] jsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'h5A;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign jsum      = {1'b0, DLY_M1} + {6'b0, lfsr[2:0]};
  assign start_cnt = jsum[8] ? 8'hFF : jsum[7:0];
`else
  assign start_cnt = DLY_M1;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= a[AW+1:2];
      q_we[wr_ptr]  <= we;
      q_be[wr_ptr]  <= be;
      q_wd[wr_ptr]  <= wd;
    end
  end

  // Memory contents survive reset, so the array lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (access && h_we) begin
      for (int i = 0; i < 4; i++) begin
        if (h_be[i]) mem[h_idx][8*i +: 8] <= h_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QW'(1);
      if (pop)  rd_ptr <= rd_ptr + QW'(1);
      case ({push, pop})
        2'b10:   count <= count + (QW+1)'(1);
        2'b01:   count <= count - (QW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rd        <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_BUSY;
            cnt   <= start_cnt;
          end
        end
        S_BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_we    <= h_we;
            rd        <= h_we ? 32'd0 : mem[h_idx];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_ram_queued.sv
// Self-checking bench for sm_ram_queued: reset values, directed vector table, queue-full,
// back-pressure and async-reset sequences, then randomized traffic against a word-array model.
module tb_sm_ram_queued;

  localparam int DELAY = 4;
  localparam int NRND  = 150;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [31:0] rd;
  logic [2:0]  pending;

  int total;
  int bad;

  logic [31:0] model_mem [64];
  logic [32:0] exp_q [$];

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  sm_ram_queued #(.SIZE(64), .DELAY(DELAY), .QDEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .we        (we),
    .be        (be),
    .wd        (wd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rd        (rd),
    .pending   (pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    int lo;
    int hi;
    lo = DELAY + 1;
`ifdef SM_RAM_QUEUED_JITTER_EN
    hi = DELAY + 8;
`else
    hi = DELAY + 1;
`endif
    total++;
    if (lat < lo || lat > hi) begin
      bad++;
      $display("FAIL %s: latency %0d edges, want %0d..%0d", name, lat, lo, hi);
    end
  endtask

  // Reference: memory is a plain word array, requests applied in issue order.
  function automatic logic [31:0] model_apply(input logic [31:0] pa, input logic pwe,
                                              input logic [3:0] pbe, input logic [31:0] pwd);
    int idx;
    idx = int'(pa[7:2]);
    if (pwe) begin
      for (int i = 0; i < 4; i++) begin
        if (pbe[i]) model_mem[idx][8*i +: 8] = pwd[8*i +: 8];
      end
      return 32'h0;
    end
    return model_mem[idx];
  endfunction

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic push(input logic [31:0] pa, input logic pwe, input logic [3:0] pbe,
                      input logic [31:0] pwd);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    a = pa;
    we = pwe;
    be = pbe;
    wd = pwd;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: req_ready stuck low for %0d cycles", guard);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic w, output logic [31:0] d, output int edges);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: no response after %0d cycles", n);
    end
    w = rsp_we;
    d = rd;
    edges = n;
    @(negedge clk);
  endtask

  initial begin
    logic        w;
    logic [31:0] d;
    logic [31:0] e [4];
    logic [31:0] x;
    int          lat;
    int          got;
    int          occ;

    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    a = 32'h0;
    we = 1'b0;
    be = 4'h0;
    wd = 32'h0;
    rsp_ready = 1'b1;

    vecs[0]  = '{32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{32'h0000_0010, 1'b0, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0020, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 32'h0};
    vecs[3]  = '{32'h0000_0020, 1'b1, 4'h5, 32'hAABB_CCDD, 1'b1, 32'h0};
    vecs[4]  = '{32'h0000_0020, 1'b0, 4'h0, 32'h0,         1'b0, 32'h11BB_33DD};
    vecs[5]  = '{32'h0000_0020, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[6]  = '{32'h0000_0022, 1'b0, 4'h0, 32'h0,         1'b0, 32'h11BB_33DD};
    vecs[7]  = '{32'h0000_0100, 1'b1, 4'hF, 32'h0123_4567, 1'b1, 32'h0};
    vecs[8]  = '{32'h0000_0000, 1'b0, 4'h0, 32'h0,         1'b0, 32'h0123_4567};
    vecs[9]  = '{32'h0000_0013, 1'b0, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{32'hFFFF_FF3C, 1'b1, 4'hF, 32'h55AA_55AA, 1'b1, 32'h0};
    vecs[11] = '{32'h0000_003C, 1'b0, 4'h0, 32'h0,         1'b0, 32'h55AA_55AA};
    vecs[12] = '{32'h0000_003C, 1'b1, 4'h6, 32'h0000_0000, 1'b1, 32'h0};
    vecs[13] = '{32'h0000_003C, 1'b0, 4'h0, 32'h0,         1'b0, 32'h5500_00AA};

    // reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_we",    32'(rsp_we),    32'd0);
    check("rst_rd",        rd,             32'd0);
    check("rst_pending",   32'(pending),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // preload the words used by later phases so no read sees uninitialised memory
    for (int i = 0; i < 16; i++) begin
      x = $urandom;
      push(32'(i * 4), 1'b1, 4'hF, x);
      void'(model_apply(32'(i * 4), 1'b1, 4'hF, x));
      wait_rsp(w, d, lat);
    end

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      push(vecs[i].a, vecs[i].we, vecs[i].be, vecs[i].wd);
      void'(model_apply(vecs[i].a, vecs[i].we, vecs[i].be, vecs[i].wd));
      wait_rsp(w, d, lat);
      check($sformatf("vec%0d_we", i), 32'(w), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
      check_lat($sformatf("vec%0d_lat", i), lat);
    end

    // queue full, then back-pressure on the first response
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e[i] = model_apply(32'((i + 1) * 4), 1'b0, 4'h0, 32'h0);
      push(32'((i + 1) * 4), 1'b0, 4'h0, 32'h0);
    end
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_pending",   32'(pending),   32'd4);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_first_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rd",    rd,             e[0]);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("pop_req_ready", 32'(req_ready), 32'd1);
    check("pop_pending",   32'(pending),   32'd3);
    rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_rsp(w, d, lat);
      check($sformatf("drain%0d_we", i), 32'(w), 32'd0);
      check($sformatf("drain%0d_rd", i), d, e[i]);
    end

    // async reset while busy with three queued writes
    push(32'h14, 1'b1, 4'hF, 32'hCAFE_F00D);
    void'(model_apply(32'h14, 1'b1, 4'hF, 32'hCAFE_F00D));
    wait_rsp(w, d, lat);
    for (int i = 0; i < 3; i++) push(32'h18, 1'b1, 4'hF, 32'h0BAD_BEEF);
    check("pre_rst_pending", 32'(pending), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_pending",   32'(pending),   32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(32'h14, 1'b0, 4'h0, 32'h0);
    wait_rsp(w, d, lat);
    check("arst_keep_rd", d, model_apply(32'h14, 1'b0, 4'h0, 32'h0));
    push(32'h18, 1'b0, 4'h0, 32'h0);
    wait_rsp(w, d, lat);
    check("arst_drop_rd", d, model_apply(32'h18, 1'b0, 4'h0, 32'h0));

    // randomized traffic with random gaps and random rsp_ready
    got = 0;
    occ = 0;
    fork
      begin
        logic [31:0] ra;
        logic        rwe;
        logic [3:0]  rbe;
        logic [31:0] rwd;
        logic [31:0] rexp;
        for (int i = 0; i < NRND; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ra = $urandom;
          ra[7:2] = 6'($urandom_range(0, 15));
          rwe = 1'($urandom_range(0, 1));
          rbe = 4'($urandom_range(0, 15));
          rwd = $urandom;
          push(ra, rwe, rbe, rwd);
          rexp = model_apply(ra, rwe, rbe, rwd);
          exp_q.push_back({rwe, rexp});
        end
      end
      begin
        int cyc;
        logic [32:0] ex;
        cyc = 0;
        while (got < NRND && cyc < 20000) begin
          @(negedge clk);
          #1;
          check("rnd_pending", 32'(pending), 32'(occ));
          rsp_ready = 1'($urandom_range(0, 1));
          if (req_valid && req_ready) occ++;
          if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rnd_extra: response with nothing outstanding, rd=%h", rd);
            end else begin
              ex = exp_q.pop_front();
              check("rnd_we", 32'(rsp_we), 32'(ex[32]));
              check("rnd_rd", rd, ex[31:0]);
            end
            occ--;
            got++;
          end
          cyc++;
        end
        if (got < NRND) begin
          total++;
          bad++;
          $display("FAIL rnd_timeout: got %0d responses, want %0d", got, NRND);
        end
      end
    join
    rsp_ready = 1'b1;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
